// File: rtl/data_mem_dumper.sv
// Post-halt memory dumper: reads data_memory words 0..end_addr and streams each word
// MSB-first as bytes to a UART transmitter using a start/done handshake.
module data_mem_dumper #(
    parameter int unsigned RAM_WIDTH     = 16,
    parameter int unsigned RAM_ADDR_BITS = 11
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [RAM_ADDR_BITS-1:0] i_end_addr,
    output logic [RAM_ADDR_BITS-1:0] o_mem_addr,
    output logic                     o_mem_write,
    input  logic [RAM_WIDTH-1:0]     i_mem_data,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned N_BYTES = (RAM_WIDTH + 7) / 8;
    localparam int unsigned PadW    = N_BYTES * 8;
    localparam int unsigned BcW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [BcW-1:0] LastByte = BcW'(N_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StSend,
        StWaitTx,
        StFin
    } state_e;

    state_e                   r_state, w_state;
    logic [RAM_ADDR_BITS-1:0] r_end_addr, w_end_addr;
    logic [RAM_ADDR_BITS-1:0] r_mem_addr, w_mem_addr;
    logic [BcW-1:0]           r_byte_cnt, w_byte_cnt;
    logic [PadW-1:0]          r_word, w_word;
    logic [7:0]               r_tx_data, w_tx_data;
    logic [PadW-1:0]          w_mem_pad;

    // Zero-extension keeps the unused top bits of the top byte at 0.
    assign w_mem_pad = PadW'(i_mem_data);

    function automatic logic [7:0] pick_byte(input logic [PadW-1:0] w, input int unsigned k);
        logic [7:0] b;
        b = '0;
        for (int unsigned j = 0; j < N_BYTES; j++) begin
            if (j == k) b = w[8*j +: 8];
        end
        return b;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_end_addr <= '0;
            r_mem_addr <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_end_addr <= w_end_addr;
            r_mem_addr <= w_mem_addr;
            r_byte_cnt <= w_byte_cnt;
            r_word     <= w_word;
            r_tx_data  <= w_tx_data;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_end_addr = r_end_addr;
        w_mem_addr = r_mem_addr;
        w_byte_cnt = r_byte_cnt;
        w_word     = r_word;
        w_tx_data  = r_tx_data;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_end_addr = i_end_addr;
                    w_mem_addr = '0;
                    w_state    = StRd;
                end
            end
            StRd: w_state = StCap;
            StCap: begin
                w_word     = w_mem_pad;
                w_byte_cnt = '0;
                w_tx_data  = pick_byte(w_mem_pad, N_BYTES - 1);
                w_state    = StSend;
            end
            StSend: w_state = StWaitTx;
            StWaitTx: begin
                if (i_tx_done) begin
                    if (r_byte_cnt < LastByte) begin
                        w_byte_cnt = r_byte_cnt + BcW'(1);
                        w_tx_data  = pick_byte(r_word, N_BYTES - 2 - 32'(r_byte_cnt));
                        w_state    = StSend;
                    end else if (r_mem_addr == r_end_addr) begin
                        // Equality stop: a full-range dump never wraps back to 0.
                        w_state = StFin;
                    end else begin
                        w_mem_addr = r_mem_addr + RAM_ADDR_BITS'(1);
                        w_state    = StRd;
                    end
                end
            end
            StFin: w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_write = 1'b0;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = (r_state == StSend);
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StFin);

endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed bench for data_mem_dumper: 16-bit build with a memory/TX model, plus a 12-bit build.
module tb_data_mem_dumper;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [10:0] end_addr, mem_addr;
    logic        mem_write;
    logic [15:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_start, tx_done, busy, done;

    logic        start2, tx_done2, mem_write2, tx_start2, busy2, done2;
    logic [10:0] mem_addr2;
    logic [11:0] mem2_data;
    logic [7:0]  tx_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_dumper #(.RAM_WIDTH(16), .RAM_ADDR_BITS(11)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_end_addr(end_addr),
        .o_mem_addr(mem_addr), .o_mem_write(mem_write), .i_mem_data(mem_data),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_busy(busy), .o_done(done)
    );

    data_mem_dumper #(.RAM_WIDTH(12), .RAM_ADDR_BITS(11)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_end_addr(11'd0),
        .o_mem_addr(mem_addr2), .o_mem_write(mem_write2), .i_mem_data(mem2_data),
        .o_tx_data(tx_data2), .o_tx_start(tx_start2), .i_tx_done(tx_done2),
        .o_busy(busy2), .o_done(done2)
    );

    // Memory with registered read.
    logic [15:0] mem [2048];
    always @(posedge clk) mem_data <= mem[mem_addr];
    always @(posedge clk) mem2_data <= (mem_addr2 == 11'd0) ? 12'hABC : 12'h000;

    // TX model: tx_done arrives tx_lat cycles after tx_start.
    int   tx_lat = 10;
    int   tx_cnt = 0;
    logic tx_done_m = 1'b0;
    logic stray = 1'b0;
    always @(posedge clk) begin
        tx_done_m <= 1'b0;
        if (!rst_n) tx_cnt <= 0;
        else if (tx_start) tx_cnt <= tx_lat - 1;
        else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_done_m <= 1'b1;
        end
    end
    assign tx_done = tx_done_m | stray;

    int tx_cnt2 = 0;
    always @(posedge clk) begin
        tx_done2 <= 1'b0;
        if (!rst_n) tx_cnt2 <= 0;
        else if (tx_start2) tx_cnt2 <= 2;
        else if (tx_cnt2 != 0) begin
            tx_cnt2 <= tx_cnt2 - 1;
            if (tx_cnt2 == 1) tx_done2 <= 1'b1;
        end
    end

    // Monitors
    logic [7:0]  bytes_q[$];
    logic [10:0] addr_q[$];
    logic [7:0]  bytes2_q[$];
    int          done_cnt = 0;
    int          done2_cnt = 0;
    bit          wr_seen = 1'b0;
    always @(posedge clk) begin
        if (tx_start) begin
            bytes_q.push_back(tx_data);
            addr_q.push_back(mem_addr);
        end
        if (tx_start2) bytes2_q.push_back(tx_data2);
        if (done) done_cnt++;
        if (done2) done2_cnt++;
        if (mem_write || mem_write2) wr_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        bytes_q.delete();
        addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [10:0] ea);
        start    = 1'b1;
        end_addr = ea;
        tick;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick;
            n++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic wait_tx_done(input int max);
        int n = 0;
        do begin
            tick;
            n++;
        end while (!tx_done && n < max);
        chk("txdone_bound", 32'(tx_done), 32'd1);
    endtask

    task automatic chk_stream_a(input string tag);
        logic [7:0]  exp_b [6] = '{8'hA1, 8'hB2, 8'h0C, 8'h0D, 8'hFF, 8'hFF};
        logic [10:0] exp_a [6] = '{11'd0, 11'd0, 11'd1, 11'd1, 11'd2, 11'd2};
        chk({tag, "_nbytes"}, bytes_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[i]), 32'(exp_b[i]));
            chk($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_a[i]));
        end
        chk({tag, "_done"}, done_cnt, 32'd1);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        end_addr = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[0] = 16'hA1B2;
        mem[1] = 16'h0C0D;
        mem[2] = 16'hFFFF;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_txstart", 32'(tx_start), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick;

        // Three-word dump
        clr;
        pulse_start(11'd2);
        chk("a_busy", 32'(busy), 32'd1);
        wait_idle(500);
        chk_stream_a("a");

        // Single word, cycle-exact latency
        clr;
        mem[0] = 16'h1234;
        pulse_start(11'd0);
        chk("b_c1_txstart", 32'(tx_start), 32'd0);
        tick;
        chk("b_c2_txstart", 32'(tx_start), 32'd0);
        tick;
        chk("b_c3_txstart", 32'(tx_start), 32'd1);
        chk("b_c3_txdata", 32'(tx_data), 32'h12);
        wait_tx_done(50);
        tick;
        chk("b_2nd_txstart", 32'(tx_start), 32'd1);
        chk("b_2nd_txdata", 32'(tx_data), 32'h34);
        wait_tx_done(50);
        chk("b_done_early", 32'(done), 32'd0);
        tick;
        chk("b_done", 32'(done), 32'd1);
        tick;
        chk("b_done_clear", 32'(done), 32'd0);
        chk("b_idle", 32'(busy), 32'd0);
        chk("b_nbytes", bytes_q.size(), 32'd2);

        // Stray tx_done in RD/CAP/SEND and a mid-dump start
        clr;
        mem[0] = 16'hA1B2;
        pulse_start(11'd2);
        stray = 1'b1;
        tick;
        tick;
        start    = 1'b1;
        end_addr = 11'd0;
        tick;
        stray = 1'b0;
        start = 1'b0;
        wait_idle(500);
        chk_stream_a("c");

        // Full-range dump
        clr;
        tx_lat = 3;
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
        pulse_start(11'h7FF);
        wait_idle(30000);
        chk("d_nbytes", bytes_q.size(), 32'd4096);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (bytes_q[2*i] !== 8'(i >> 8) || bytes_q[2*i+1] !== 8'(i)) bad++;
        end
        chk("d_bytes_bad", bad, 32'd0);
        chk("d_last_hi", 32'(bytes_q[4094]), 32'h07);
        chk("d_last_lo", 32'(bytes_q[4095]), 32'hFF);
        chk("d_done", done_cnt, 32'd1);
        chk("d_addr_end", 32'(mem_addr), 32'h7FF);
        repeat (5) tick;
        chk("d_no_wrap", bytes_q.size(), 32'd4096);
        chk("d_stay_idle", 32'(busy), 32'd0);

        // Reset during WAIT_TX of word 1, with start asserted alongside reset
        clr;
        tx_lat = 10;
        mem[0] = 16'hA1B2;
        mem[1] = 16'h0C0D;
        mem[2] = 16'hFFFF;
        pulse_start(11'd2);
        bad = 0;
        while (bytes_q.size() < 3 && bad < 200) begin
            tick;
            bad++;
        end
        chk("e_reach_w1", bytes_q.size(), 32'd3);
        tick;
        rst_n = 1'b0;
        start = 1'b1;
        tick;
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_addr", 32'(mem_addr), 32'd0);
        chk("e_txstart", 32'(tx_start), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (15) tick;
        chk("e_quiet_bytes", bytes_q.size(), 32'd3);
        chk("e_quiet_busy", 32'(busy), 32'd0);
        chk("e_no_done", done_cnt, 32'd0);
        clr;
        pulse_start(11'd2);
        wait_idle(500);
        chk_stream_a("e");

        // 12-bit build
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        bad = 0;
        while (busy2 && bad < 200) begin
            tick;
            bad++;
        end
        chk("f_idle", 32'(busy2), 32'd0);
        chk("f_nbytes", bytes2_q.size(), 32'd2);
        chk("f_byte0", 32'(bytes2_q[0]), 32'h0A);
        chk("f_byte1", 32'(bytes2_q[1]), 32'hBC);
        chk("f_done", done2_cnt, 32'd1);

        chk("mem_write_never", 32'(wr_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
